// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, funct3 size codes and arbiter defaults.
package dmem_pkg;
  typedef enum logic {ST_CPU = 1'b0, ST_EXT_LOCK = 1'b1} state_e;
  localparam logic [2:0] FN_LB  = 3'b000;
  localparam logic [2:0] FN_LH  = 3'b001;
  localparam logic [2:0] FN_LW  = 3'b010;
  localparam logic [2:0] FN_LBU = 3'b100;
  localparam logic [2:0] FN_LHU = 3'b101;
  localparam int STARVE_MAX_DEF = 4;
  localparam int LOCK_MAX_DEF   = 8;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, EXT and Data_Memory signals around the arbiter; slave is the arbiter side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic [2:0]        cpu_funct3;
  logic              ext_req, ext_lock, ext_we, ext_gnt, ext_rvalid;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata, ext_rdata;
  logic [2:0]        ext_funct3;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we;
  logic [2:0]        mem_funct3;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  ext_req, ext_lock, ext_we, ext_addr, ext_wdata, ext_funct3,
    output ext_gnt, ext_rdata, ext_rvalid,
    output mem_addr, mem_wdata, mem_we, mem_funct3,
    input  mem_rdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output ext_req, ext_lock, ext_we, ext_addr, ext_wdata, ext_funct3,
    input  ext_gnt, ext_rdata, ext_rvalid,
    input  mem_addr, mem_wdata, mem_we, mem_funct3,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arb_rdreg.sv
// dmem_arb_rdreg: registers memory read data on a granted read and pulses rvalid one cycle later.
module dmem_arb_rdreg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fire_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o
);
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= fire_i ? rdata_i : rdata_q;
      rvalid_q <= fire_i;
    end
  end
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares Data_Memory between CPU (priority) and EXT with starvation guard and bounded lock.
// Defining DMEM_ARB_STATS_EN adds saturating grant/stall counters on extra ports.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
  input logic Clk,
  input logic Reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0] cpu_grant_cnt,
  output logic [31:0] ext_grant_cnt,
  output logic [31:0] cpu_stall_cnt
`endif
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [3:0] LMAX = 4'(LOCK_MAX);
  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d, lock_q, lock_d;
  logic              grant_cpu, grant_ext, lock_hold;
  logic [ADDR_W-1:0] addr_sel;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_CPU;
      starve_q <= 4'd0;
      lock_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      lock_q   <= lock_d;
    end
  end
  // lock_q counts EXT beats of the current locked run, including the beat that opened it
  always_comb begin
    state_d  = (grant_ext && bus.ext_lock && ({1'b0, lock_q} + 5'd1 < {1'b0, LMAX})) ? ST_EXT_LOCK : ST_CPU;
    lock_d   = (state_d == ST_EXT_LOCK) ? lock_q + 4'd1 : 4'd0;
    starve_d = (grant_ext || !bus.ext_req) ? 4'd0 : (starve_q == SMAX ? starve_q : starve_q + 4'd1);
  end
  always_comb begin
    lock_hold      = (state_q == ST_EXT_LOCK) && bus.ext_req && (lock_q < LMAX);
    grant_ext      = lock_hold || (bus.ext_req && (!bus.cpu_req || starve_q == SMAX));
    grant_cpu      = bus.cpu_req && !grant_ext;
    addr_sel       = grant_ext ? bus.ext_addr : bus.cpu_addr;
    bus.mem_addr   = addr_sel;
    bus.mem_wdata  = grant_ext ? bus.ext_wdata : bus.cpu_wdata;
    bus.mem_funct3 = grant_ext ? bus.ext_funct3 : bus.cpu_funct3;
    bus.mem_we     = grant_ext ? bus.ext_we : (grant_cpu && bus.cpu_we);
    bus.cpu_stall  = bus.cpu_req && !grant_cpu;
    bus.ext_gnt    = grant_ext;
  end
  dmem_arb_rdreg #(.DATA_W(DATA_W)) u_cpu_rd (
    .clk(Clk), .rst(Reset), .fire_i(grant_cpu && !bus.cpu_we), .rdata_i(bus.mem_rdata),
    .rdata_o(bus.cpu_rdata), .rvalid_o(bus.cpu_rvalid)
  );
  dmem_arb_rdreg #(.DATA_W(DATA_W)) u_ext_rd (
    .clk(Clk), .rst(Reset), .fire_i(grant_ext && !bus.ext_we), .rdata_i(bus.mem_rdata),
    .rdata_o(bus.ext_rdata), .rvalid_o(bus.ext_rvalid)
  );
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] cpu_grant_cnt_q, ext_grant_cnt_q, cpu_stall_cnt_q;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cpu_grant_cnt_q <= '0;
      ext_grant_cnt_q <= '0;
      cpu_stall_cnt_q <= '0;
    end else begin
      cpu_grant_cnt_q <= cpu_grant_cnt_q + 32'(grant_cpu && cpu_grant_cnt_q != '1);
      ext_grant_cnt_q <= ext_grant_cnt_q + 32'(grant_ext && ext_grant_cnt_q != '1);
      cpu_stall_cnt_q <= cpu_stall_cnt_q + 32'(bus.cpu_stall && cpu_stall_cnt_q != '1);
    end
  end
  assign cpu_grant_cnt = cpu_grant_cnt_q;
  assign ext_grant_cnt = ext_grant_cnt_q;
  assign cpu_stall_cnt = cpu_stall_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scenario tasks plus a randomized run against a behavioural arbitration model.
module tb_dmem_arbiter;
  import dmem_pkg::*;
  localparam int STARVE_MAX = 4;
  localparam int LOCK_MAX   = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass_cnt = 0;
  int total = 0;
  dmem_arbiter_if bus ();
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] cpu_grant_cnt, ext_grant_cnt, cpu_stall_cnt;
`endif
  dmem_arbiter #(.STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)) dut (
    .Clk(clk), .Reset(rst), .bus(bus)
`ifdef DMEM_ARB_STATS_EN
    , .cpu_grant_cnt(cpu_grant_cnt), .ext_grant_cnt(ext_grant_cnt), .cpu_stall_cnt(cpu_stall_cnt)
`endif
  );
  always #5 clk = ~clk;

  // byte-addressed Data_Memory stand-in, 256 bytes, combinational read with funct3 formatting
  logic [7:0] mem [256] = '{default: 8'h00};
  function automatic logic [31:0] mem_load(input logic [31:0] a, input logic [2:0] f);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a[7:0]];
    b1 = mem[a[7:0] + 8'd1];
    b2 = mem[a[7:0] + 8'd2];
    b3 = mem[a[7:0] + 8'd3];
    case (f)
      FN_LB:   return {{24{b0[7]}}, b0};
      FN_LH:   return {{16{b1[7]}}, b1, b0};
      FN_LBU:  return {24'd0, b0};
      FN_LHU:  return {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction
  always_comb bus.mem_rdata = mem_load(bus.mem_addr, bus.mem_funct3);
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata[7:0];
      if (bus.mem_funct3[1:0] != 2'b00) mem[bus.mem_addr[7:0] + 8'd1] <= bus.mem_wdata[15:8];
      if (bus.mem_funct3[1:0] == 2'b10) begin
        mem[bus.mem_addr[7:0] + 8'd2] <= bus.mem_wdata[23:16];
        mem[bus.mem_addr[7:0] + 8'd3] <= bus.mem_wdata[31:24];
      end
    end
  end

  // reference model: EXT waiting time, length of the current locked EXT run, expected read returns
  int          m_wait = 0, m_run = 0;
  bit          m_locked = 0;
  logic        exp_cg, exp_eg, exp_we, exp_stall;
  logic        exp_crv = 1'b0, exp_erv = 1'b0;
  logic [31:0] exp_addr, exp_wd, exp_crd = '0, exp_erd = '0, pend_cd, pend_ed;
  logic [2:0]  exp_f3;

  task automatic model_comb();
    exp_eg    = bus.ext_req && ((m_locked && m_run < LOCK_MAX) || !bus.cpu_req || m_wait >= STARVE_MAX);
    exp_cg    = bus.cpu_req && !exp_eg;
    exp_stall = bus.cpu_req && !exp_cg;
    exp_we    = exp_eg ? bus.ext_we : (exp_cg && bus.cpu_we);
    exp_addr  = exp_eg ? bus.ext_addr : bus.cpu_addr;
    exp_wd    = exp_eg ? bus.ext_wdata : bus.cpu_wdata;
    exp_f3    = exp_eg ? bus.ext_funct3 : bus.cpu_funct3;
    pend_cd   = mem_load(bus.cpu_addr, bus.cpu_funct3);
    pend_ed   = mem_load(bus.ext_addr, bus.ext_funct3);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_wait = 0; m_run = 0; m_locked = 0;
      exp_crv = 0; exp_erv = 0; exp_crd = '0; exp_erd = '0;
    end else begin
      exp_crv = exp_cg && !bus.cpu_we;
      exp_erv = exp_eg && !bus.ext_we;
      if (exp_crv) exp_crd = pend_cd;
      if (exp_erv) exp_erd = pend_ed;
      m_wait = (exp_eg || !bus.ext_req) ? 0 : (m_wait < STARVE_MAX ? m_wait + 1 : STARVE_MAX);
      if (exp_eg && bus.ext_lock && m_run + 1 < LOCK_MAX) begin
        m_locked = 1; m_run++;
      end else begin
        m_locked = 0; m_run = 0;
      end
    end
  endtask

  task automatic drive(input logic cr, cwe, input logic [31:0] ca, cwd, input logic [2:0] cf,
                       input logic er, el, ewe, input logic [31:0] ea, ewd, input logic [2:0] ef);
    bus.cpu_req = cr; bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_wdata = cwd; bus.cpu_funct3 = cf;
    bus.ext_req = er; bus.ext_lock = el; bus.ext_we = ewe; bus.ext_addr = ea; bus.ext_wdata = ewd;
    bus.ext_funct3 = ef;
  endtask

  task automatic step_pre();
    @(negedge clk);
    model_comb();
  endtask

  task automatic step_post();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0, FN_LW, 0, 0, 0, 0, 0, FN_LW);
    step_pre();
    step_post();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, FN_LW, 0, 0, 0, 0, 0, FN_LW);
    step_pre();
    step_post();
    step_pre();
    total++;
    if (bus.cpu_stall !== 1'b0 || bus.ext_gnt !== 1'b0 || bus.mem_we !== 1'b0)
      $display("FAIL reset_comb: stall=%b gnt=%b we=%b, want 0 0 0", bus.cpu_stall, bus.ext_gnt, bus.mem_we);
    else pass_cnt++;
    step_post();
    total++;
    if (bus.cpu_rvalid !== 1'b0 || bus.ext_rvalid !== 1'b0 || bus.cpu_rdata !== 32'd0 || bus.ext_rdata !== 32'd0)
      $display("FAIL reset_regs: crv=%b erv=%b crd=%h erd=%h, want all 0",
               bus.cpu_rvalid, bus.ext_rvalid, bus.cpu_rdata, bus.ext_rdata);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_cpu_load();
    drive(1, 1, 32'h10, 32'hDEADBEEF, FN_LW, 0, 0, 0, 0, 0, FN_LW);
    step_pre();
    total++;
    if (bus.cpu_stall !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_wdata !== 32'hDEADBEEF)
      $display("FAIL cpu_store: stall=%b we=%b addr=%h wd=%h, want 0 1 10 deadbeef",
               bus.cpu_stall, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    else pass_cnt++;
    step_post();
    total++;
    if (bus.cpu_rvalid !== 1'b0) $display("FAIL cpu_store_rvalid: got %b, want 0", bus.cpu_rvalid);
    else pass_cnt++;
    drive(1, 0, 32'h10, 32'h0, FN_LW, 0, 0, 0, 0, 0, FN_LW);
    step_pre();
    total++;
    if (bus.cpu_stall !== 1'b0 || bus.mem_we !== 1'b0)
      $display("FAIL cpu_load_grant: stall=%b we=%b, want 0 0", bus.cpu_stall, bus.mem_we);
    else pass_cnt++;
    step_post();
    total++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF)
      $display("FAIL cpu_load_data: rvalid=%b rdata=%h, want 1 deadbeef", bus.cpu_rvalid, bus.cpu_rdata);
    else pass_cnt++;
    idle_cycle();
    total++;
    if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'hDEADBEEF)
      $display("FAIL cpu_load_pulse: rvalid=%b rdata=%h, want 0 deadbeef", bus.cpu_rvalid, bus.cpu_rdata);
    else pass_cnt++;
  endtask

  task automatic test_starve();
    logic [5:0] pat = 6'b010000;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] c0 = cpu_grant_cnt, e0 = ext_grant_cnt, s0 = cpu_stall_cnt;
`endif
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 32'h40, 0, FN_LW, i < 5, 0, 0, 32'h80, 0, FN_LW);
      step_pre();
      total++;
      if (bus.ext_gnt !== pat[i] || bus.cpu_stall !== pat[i] || bus.mem_addr !== (pat[i] ? 32'h80 : 32'h40))
        $display("FAIL starve c%0d: gnt=%b stall=%b addr=%h, want %b %b %h", i, bus.ext_gnt, bus.cpu_stall,
                 bus.mem_addr, pat[i], pat[i], pat[i] ? 32'h80 : 32'h40);
      else pass_cnt++;
      step_post();
      total++;
      if (bus.cpu_rvalid !== !pat[i] || bus.ext_rvalid !== pat[i])
        $display("FAIL starve_rv c%0d: crv=%b erv=%b, want %b %b", i, bus.cpu_rvalid, bus.ext_rvalid, !pat[i], pat[i]);
      else pass_cnt++;
`ifdef DMEM_ARB_STATS_EN
      if (i == 4) begin
        total++;
        if (cpu_grant_cnt - c0 !== 32'd4 || ext_grant_cnt - e0 !== 32'd1 || cpu_stall_cnt - s0 !== 32'd1)
          $display("FAIL stats: cpu_g=%0d ext_g=%0d stall=%0d, want 4 1 1",
                   cpu_grant_cnt - c0, ext_grant_cnt - e0, cpu_stall_cnt - s0);
        else pass_cnt++;
      end
`endif
    end
    idle_cycle();
  endtask

  task automatic test_lock_burst();
    int beats = 0, cyc = 0, first = -1, run = 0;
    bit g[$];
    while (beats < 10 && cyc < 60) begin
      drive(1, 0, 32'h44, 0, FN_LW, 1, 1, 0, 32'(128 + 4 * beats), 0, FN_LW);
      step_pre();
      total++;
      if (bus.ext_gnt !== exp_eg || bus.cpu_stall !== exp_stall)
        $display("FAIL lock c%0d: gnt=%b stall=%b, want %b %b", cyc, bus.ext_gnt, bus.cpu_stall, exp_eg, exp_stall);
      else pass_cnt++;
      g.push_back(bus.ext_gnt === 1'b1);
      if (exp_eg) beats++;
      step_post();
      cyc++;
    end
    total++;
    if (beats != 10) $display("FAIL lock_timeout: beats=%0d, want 10", beats);
    else pass_cnt++;
    foreach (g[i]) if (g[i] && first < 0) first = i;
    if (first >= 0) while (first + run < g.size() && g[first + run]) run++;
    total++;
    if (run != LOCK_MAX) $display("FAIL lock_run: got %0d beats, want %0d", run, LOCK_MAX);
    else pass_cnt++;
    total++;
    if (first < 0 || first + run >= g.size() || g[first + run])
      $display("FAIL lock_release: first=%0d run=%0d, want CPU grant after run", first, run);
    else pass_cnt++;
    idle_cycle();
  endtask

  task automatic test_ext_sb();
    drive(0, 0, 0, 0, FN_LW, 1, 0, 1, 32'h21, 32'h000000AB, FN_LB);
    step_pre();
    total++;
    if (bus.ext_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h21 || bus.mem_funct3 !== FN_LB)
      $display("FAIL ext_sb: gnt=%b we=%b addr=%h f3=%b, want 1 1 21 000",
               bus.ext_gnt, bus.mem_we, bus.mem_addr, bus.mem_funct3);
    else pass_cnt++;
    step_post();
    total++;
    if (bus.ext_rvalid !== 1'b0) $display("FAIL ext_sb_rvalid: got %b, want 0", bus.ext_rvalid);
    else pass_cnt++;
    drive(1, 0, 32'h21, 0, FN_LBU, 0, 0, 0, 0, 0, FN_LW);
    step_pre();
    step_post();
    total++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h000000AB)
      $display("FAIL cpu_lbu: rvalid=%b rdata=%h, want 1 000000ab", bus.cpu_rvalid, bus.cpu_rdata);
    else pass_cnt++;
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    logic [5:0] pat = 6'b010000;
    bit got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      drive(1, 0, 32'h44, 0, FN_LW, 1, 1, 0, 32'h48, 0, FN_LW);
      step_pre();
      got = (bus.ext_gnt === 1'b1);
      step_post();
    end
    total++;
    if (!got) $display("FAIL reset_mid_timeout: ext_gnt never seen, want 1 within 10 cycles");
    else pass_cnt++;
    rst = 1'b1;
    drive(1, 0, 32'h44, 0, FN_LW, 1, 1, 0, 32'h4C, 0, FN_LW);
    step_pre();
    total++;
    if (bus.ext_gnt !== 1'b1 || bus.cpu_stall !== 1'b1)
      $display("FAIL reset_mid_lock: gnt=%b stall=%b, want 1 1", bus.ext_gnt, bus.cpu_stall);
    else pass_cnt++;
    step_post();
    rst = 1'b0;
    total++;
    if (bus.ext_rvalid !== 1'b0 || bus.ext_rdata !== 32'd0 || bus.cpu_rvalid !== 1'b0)
      $display("FAIL reset_mid_rv: erv=%b erd=%h crv=%b, want 0 0 0", bus.ext_rvalid, bus.ext_rdata, bus.cpu_rvalid);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 32'h44, 0, FN_LW, i < 5, 0, 0, 32'h4C, 0, FN_LW);
      step_pre();
      total++;
      if (bus.ext_gnt !== pat[i] || bus.cpu_stall !== pat[i])
        $display("FAIL reset_mid_after c%0d: gnt=%b stall=%b, want %b %b", i, bus.ext_gnt, bus.cpu_stall, pat[i], pat[i]);
      else pass_cnt++;
      step_post();
    end
    idle_cycle();
  endtask

  function automatic logic [2:0] rand_f3(input logic we);
    logic [2:0] rd [5] = '{FN_LB, FN_LH, FN_LW, FN_LBU, FN_LHU};
    return we ? rd[$urandom_range(0, 2)] : rd[$urandom_range(0, 4)];
  endfunction

  function automatic logic [31:0] rand_addr(input logic [2:0] f);
    logic [31:0] a = 32'($urandom_range(0, 255));
    return f[1:0] == 2'b10 ? (a & 32'hFC) : (f[1:0] == 2'b01 ? (a & 32'hFE) : a);
  endfunction

  task automatic test_random();
    bit e_pend = 0;
    logic ewe = 0, cwe;
    logic [31:0] ea = 0, ewd = 0, ca;
    logic [2:0] ef = FN_LW, cf;
    for (int c = 0; c < 400; c++) begin
      if (!e_pend && $urandom_range(0, 2) == 0) begin
        e_pend = 1;
        ewe = 1'($urandom_range(0, 1));
        ef = rand_f3(ewe);
        ea = rand_addr(ef);
        ewd = $urandom;
      end
      cwe = 1'($urandom_range(0, 1));
      cf = rand_f3(cwe);
      ca = rand_addr(cf);
      drive($urandom_range(0, 9) < 6, cwe, ca, $urandom, cf, e_pend, $urandom_range(0, 3) != 0, ewe, ea, ewd, ef);
      step_pre();
      total++;
      if (bus.cpu_stall !== exp_stall || bus.ext_gnt !== exp_eg || bus.mem_we !== exp_we ||
          bus.mem_addr !== exp_addr || bus.mem_wdata !== exp_wd || bus.mem_funct3 !== exp_f3)
        $display("FAIL rand_comb c%0d: stall=%b gnt=%b we=%b addr=%h wd=%h f3=%b, want %b %b %b %h %h %b", c,
                 bus.cpu_stall, bus.ext_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_funct3,
                 exp_stall, exp_eg, exp_we, exp_addr, exp_wd, exp_f3);
      else pass_cnt++;
      if (exp_eg) e_pend = 0;
      step_post();
      total++;
      if (bus.cpu_rvalid !== exp_crv || bus.ext_rvalid !== exp_erv || bus.cpu_rdata !== exp_crd || bus.ext_rdata !== exp_erd)
        $display("FAIL rand_rd c%0d: crv=%b erv=%b crd=%h erd=%h, want %b %b %h %h", c, bus.cpu_rvalid,
                 bus.ext_rvalid, bus.cpu_rdata, bus.ext_rdata, exp_crv, exp_erv, exp_crd, exp_erd);
      else pass_cnt++;
    end
    while (e_pend) begin
      drive(0, 0, 0, 0, FN_LW, 1, 0, ewe, ea, ewd, ef);
      step_pre();
      e_pend = 0;
      step_post();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, FN_LW, 0, 0, 0, 0, 0, FN_LW);
    test_reset();
    test_cpu_load();
    test_starve();
    test_lock_burst();
    test_ext_sb();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
